// File: rtl/layer4_frame_loader.sv
// Serial-to-parallel frame loader feeding the layer-4 nodes; frames appear on A*x one edge after the last word.
// Holds in_ready low for NODE_LAT cycles after each load, then pulses node_valid and resumes filling.
module layer4_frame_loader #(
    parameter int NUM_IN   = 15,
    parameter int NODE_LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        clear,
    output logic [15:0] A0x,
    output logic [15:0] A1x,
    output logic [15:0] A2x,
    output logic [15:0] A3x,
    output logic [15:0] A4x,
    output logic [15:0] A5x,
    output logic [15:0] A6x,
    output logic [15:0] A7x,
    output logic [15:0] A8x,
    output logic [15:0] A9x,
    output logic [15:0] A10x,
    output logic [15:0] A11x,
    output logic [15:0] A12x,
    output logic [15:0] A13x,
    output logic [15:0] A14x,
    output logic        frame_valid,
    output logic        node_valid,
    output logic [3:0]  fill_count
);

    typedef enum logic {FILL, HOLD} state_t;

    localparam logic [3:0] FILL_LAST = 4'(NUM_IN - 1);
    localparam logic [2:0] HOLD_LAST = 3'(NODE_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  fill_cnt_q, fill_cnt_d;
    logic [2:0]  hold_cnt_q, hold_cnt_d;
    logic [15:0] stage_q [15];
    logic [15:0] stage_d [15];
    logic [15:0] a_q [15];
    logic [15:0] a_d [15];
    logic [15:0] a_out [15];
    logic        frame_valid_q, frame_valid_d;
    logic        node_valid_q, node_valid_d;

    always_comb begin
        state_d       = state_q;
        fill_cnt_d    = fill_cnt_q;
        hold_cnt_d    = hold_cnt_q;
        stage_d       = stage_q;
        a_d           = a_q;
        frame_valid_d = 1'b0;
        node_valid_d  = 1'b0;
        case (state_q)
            FILL: begin
                // clear beats a simultaneous accept, even on the completing word
                if (clear) begin
                    fill_cnt_d = 4'd0;
                end else if (in_valid) begin
                    stage_d[fill_cnt_q] = in_data;
                    if (fill_cnt_q == FILL_LAST) begin
                        a_d           = stage_d;
                        fill_cnt_d    = 4'd0;
                        hold_cnt_d    = 3'd0;
                        state_d       = HOLD;
                        frame_valid_d = 1'b1;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 4'd1;
                    end
                end
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d   = 3'd0;
                    state_d      = FILL;
                    node_valid_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 3'd1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FILL;
            fill_cnt_q    <= 4'd0;
            hold_cnt_q    <= 3'd0;
            stage_q       <= '{default: '0};
            a_q           <= '{default: '0};
            frame_valid_q <= 1'b0;
            node_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            fill_cnt_q    <= fill_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            stage_q       <= stage_d;
            a_q           <= a_d;
            frame_valid_q <= frame_valid_d;
            node_valid_q  <= node_valid_d;
        end
    end

    for (genvar k = 0; k < 15; k++) begin : g_tie
        assign a_out[k] = (k < NUM_IN) ? a_q[k] : 16'h0000;
    end

    assign in_ready    = (state_q == FILL);
    assign frame_valid = frame_valid_q;
    assign node_valid  = node_valid_q;
    assign fill_count  = fill_cnt_q;

    assign A0x  = a_out[0];
    assign A1x  = a_out[1];
    assign A2x  = a_out[2];
    assign A3x  = a_out[3];
    assign A4x  = a_out[4];
    assign A5x  = a_out[5];
    assign A6x  = a_out[6];
    assign A7x  = a_out[7];
    assign A8x  = a_out[8];
    assign A9x  = a_out[9];
    assign A10x = a_out[10];
    assign A11x = a_out[11];
    assign A12x = a_out[12];
    assign A13x = a_out[13];
    assign A14x = a_out[14];

endmodule

// File: tb/tb_layer4_frame_loader.sv
// Bench for layer4_frame_loader: directed scenarios plus random traffic against a queue-based frame model.
module tb_layer4_frame_loader;

    localparam int NUM_IN   = 15;
    localparam int NODE_LAT = 3;

    logic        clk = 1'b0;
    logic        reset, clear, in_valid;
    logic [15:0] in_data;
    logic        in_ready, frame_valid, node_valid;
    logic [3:0]  fill_count;
    logic [15:0] a_obs [15];

    int n_chk  = 0;
    int n_pass = 0;

    // model state: words accepted so far, last loaded frame, remaining hold cycles
    int          m_q[$];
    logic [15:0] m_a [15];
    int          m_hold_left;
    bit          m_busy, m_fv, m_nv;

    always #5 clk = ~clk;

    layer4_frame_loader #(.NUM_IN(NUM_IN), .NODE_LAT(NODE_LAT)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .clear(clear),
        .A0x(a_obs[0]), .A1x(a_obs[1]), .A2x(a_obs[2]), .A3x(a_obs[3]),
        .A4x(a_obs[4]), .A5x(a_obs[5]), .A6x(a_obs[6]), .A7x(a_obs[7]),
        .A8x(a_obs[8]), .A9x(a_obs[9]), .A10x(a_obs[10]), .A11x(a_obs[11]),
        .A12x(a_obs[12]), .A13x(a_obs[13]), .A14x(a_obs[14]),
        .frame_valid(frame_valid), .node_valid(node_valid), .fill_count(fill_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_edge(input bit rst, input bit clr, input bit vld, input logic [15:0] dat);
        if (rst) begin
            m_q.delete();
            foreach (m_a[k]) m_a[k] = 16'h0;
            m_busy = 0; m_hold_left = 0; m_fv = 0; m_nv = 0;
            return;
        end
        m_fv = 0; m_nv = 0;
        if (m_busy) begin
            m_hold_left--;
            if (m_hold_left == 0) begin m_busy = 0; m_nv = 1; end
        end else if (clr) begin
            m_q.delete();
        end else if (vld) begin
            m_q.push_back(int'(dat));
            if (m_q.size() == NUM_IN) begin
                foreach (m_a[k]) m_a[k] = (k < NUM_IN) ? 16'(m_q[k]) : 16'h0;
                m_q.delete();
                m_busy = 1; m_hold_left = NODE_LAT; m_fv = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("in_ready", 32'(in_ready), 32'(!m_busy));
        chk("fill_count", 32'(fill_count), 32'(m_q.size()));
        chk("frame_valid", 32'(frame_valid), 32'(m_fv));
        chk("node_valid", 32'(node_valid), 32'(m_nv));
        for (int k = 0; k < 15; k++) chk($sformatf("A%0dx", k), 32'(a_obs[k]), 32'(m_a[k]));
    endtask

    task automatic step(input bit rst, input bit clr, input bit vld, input logic [15:0] dat);
        @(negedge clk);
        reset = rst; clear = clr; in_valid = vld; in_data = dat;
        @(posedge clk);
        model_edge(rst, clr, vld, dat);
        #1;
        check_all();
    endtask

    task automatic wait_ready(input logic [15:0] dat);
        for (int i = 0; i < 20 && !in_ready; i++) step(0, 0, 1, dat);
        chk("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen_fv;
        reset = 1; clear = 0; in_valid = 0; in_data = 16'h0;
        step(1, 0, 0, 16'h0);
        step(0, 0, 0, 16'h0);

        // basic frame 1..15 with in_valid held high, then back-pressure with 0xDEAD
        for (int i = 1; i <= NUM_IN; i++) step(0, 0, 1, 16'(i));
        chk("basic_fv", 32'(frame_valid), 32'd1);
        chk("basic_a0", 32'(a_obs[0]), 32'h0001);
        chk("basic_a14", 32'(a_obs[14]), 32'h000F);
        for (int i = 0; i < NODE_LAT; i++) step(0, 0, 1, 16'hDEAD);
        chk("basic_nv", 32'(node_valid), 32'd1);
        chk("bp_no_capture", 32'(fill_count), 32'd0);

        // gaps: valid toggling
        for (int i = 1; i <= NUM_IN; i++) begin
            step(0, 0, 1, 16'(i));
            if (i != NUM_IN) step(0, 0, 0, 16'hBEEF);
        end
        chk("gap_a7", 32'(a_obs[7]), 32'h0008);
        for (int i = 0; i < NODE_LAT; i++) step(0, 0, 0, 16'h0);

        // clear after 7 words, including clear with valid high
        for (int i = 0; i < 7; i++) step(0, 0, 1, 16'h1000 + 16'(i));
        step(0, 1, 1, 16'h5555);
        chk("clear_fc", 32'(fill_count), 32'd0);
        for (int i = 0; i < NUM_IN - 1; i++) step(0, 0, 1, 16'h2000 + 16'(i));
        step(0, 1, 1, 16'h2FFF);   // clear on the completing word: no load
        chk("clear_last_fv", 32'(frame_valid), 32'd0);
        for (int i = 0; i < NUM_IN; i++) step(0, 0, 1, 16'h3000 + 16'(i));
        chk("clear_a0", 32'(a_obs[0]), 32'h3000);

        // clear during HOLD is ignored; reset one cycle after frame_valid
        step(0, 1, 0, 16'h0);
        step(1, 0, 1, 16'h0);
        chk("rst_hold_a0", 32'(a_obs[0]), 32'h0);
        for (int i = 0; i < NODE_LAT + 1; i++) step(0, 0, 0, 16'h0);

        // signed boundaries
        for (int i = 0; i < NUM_IN; i++)
            step(0, 0, 1, (i == 0) ? 16'h8000 : (i == 1) ? 16'h7FFF : (i == 14) ? 16'hFFFF : 16'(i));
        chk("sgn_a0", 32'(a_obs[0]), 32'h8000);
        chk("sgn_a1", 32'(a_obs[1]), 32'h7FFF);
        chk("sgn_a14", 32'(a_obs[14]), 32'hFFFF);
        wait_ready(16'h0);

        // random traffic
        seen_fv = 0;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 399) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) < 7, 16'($urandom));
            if (frame_valid) seen_fv++;
        end
        chk("rand_frames_seen", 32'(seen_fv > 20), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/layer4_frame_loader.md
LAYER4_FRAME_LOADER -- requirements
Module: layer4_frame_loader

Interface
REQ-001 SHALL have parameter NUM_IN, default 15: activations per frame, range 2-15.
REQ-002 SHALL have parameter NODE_LAT, default 3: clocks from a frame load to valid layer-4 node output, range 1-7.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_data  input  16  serial activation word, two's complement.
REQ-006 SHALL have port in_valid  input  1  in_data valid this cycle.
REQ-007 SHALL have port in_ready  output  1  loader accepts a word this cycle.
REQ-008 SHALL have port clear  input  1  synchronous abort of a partially filled frame.
REQ-009 SHALL have ports A0x..A14x  output  16 each  parallel frame to the layer-4 node inputs; Ak for k>=NUM_IN SHALL be tied to 0.
REQ-010 SHALL have port frame_valid  output  1  one-cycle pulse on a new frame at A*x.
REQ-011 SHALL have port node_valid  output  1  one-cycle pulse marking the cycle in which node outputs for the current frame are valid.
REQ-012 SHALL have port fill_count  output  4  words held in the staging buffer.

Function
REQ-013 SHALL implement states FILL and HOLD; in_ready SHALL be 1 in FILL and 0 in HOLD, decoded from state only.
REQ-014 In FILL, an accept (in_valid & in_ready) SHALL write in_data into staging slot fill_count, then increment fill_count.
REQ-015 Staging writes SHALL be in arrival order: the first accepted word of a frame goes to A0x, the k-th to A(k-1)x.
REQ-016 On the accept that makes the frame complete (fill_count = NUM_IN-1 before the edge), the same edge SHALL load all NUM_IN words (including the current one) into A*x at once, reset fill_count to 0, and enter HOLD.
REQ-017 A*x SHALL change only on the frame-load edge and hold their values until the next frame load.
REQ-018 frame_valid SHALL be 1 for exactly the cycle after the frame-load edge.
REQ-019 HOLD SHALL last exactly NODE_LAT cycles, counted by a 3-bit counter.
REQ-020 node_valid SHALL be 1 for exactly one cycle, beginning NODE_LAT edges after the frame-load edge.
REQ-021 The edge that raises node_valid SHALL return the FSM to FILL, so in_ready is 1 in the node_valid cycle.
REQ-022 in_data SHALL be ignored when in_valid=0 or in_ready=0; no word is lost or duplicated.
REQ-023 clear=1 in FILL SHALL zero fill_count and discard staged words; A*x are unchanged.
REQ-024 clear=1 in HOLD SHALL have no effect.
REQ-025 clear=1 with a simultaneous accept SHALL drop the word (clear wins), including on the frame-completing word; no frame load occurs.
REQ-026 Data SHALL pass bit-exact with no arithmetic, saturation or sign change.

Reset
REQ-027 reset=1 SHALL, at the next edge, set state=FILL, fill_count=0, A*x=0, staging=0, HOLD counter=0, frame_valid=0, node_valid=0.
REQ-028 reset SHALL take priority over clear and in_valid, and over any mid-frame or mid-HOLD activity.
REQ-029 In the cycle after reset is deasserted, in_ready SHALL be 1.

Verification
REQ-030 Basic frame: reset, then stream 0x0001..0x000F with in_valid held high -> frame_valid at cycle 16 after the first accept; A0x=0x0001 ... A14x=0x000F; node_valid exactly 3 cycles after frame_valid; in_ready 0 for those 3 cycles.
REQ-031 Gaps: same data with in_valid toggling 1,0,1,0 -> identical A*x; fill_count steps only on accepts.
REQ-032 Back-pressure: hold in_valid=1 through HOLD with in_data=0xDEAD -> 0xDEAD is not captured; the next frame starts at the node_valid cycle.
REQ-033 Clear: 7 words accepted, then clear with in_valid=1 -> fill_count=0; the next 15 words form the frame; prior A*x stay unchanged until that load.
REQ-034 Reset mid-HOLD: assert reset 1 cycle after frame_valid -> A*x=0, no node_valid pulse, in_ready=1 after release.
REQ-035 Signed boundaries: frame containing 0x8000, 0x7FFF and 0xFFFF -> the same values appear on the corresponding A*x.
